// File: rtl/control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a phase-gated control word.
// FETCH and MEM wait on their acks indefinitely; every other phase lasts exactly one cycle.
module control_fsm #(
    parameter int INSTR_W = 8,
    parameter int OPW     = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               fetch_ack,
    input  logic               mem_ack,
    output logic               fetch_req,
    output logic [12:0]        ctrl,
    output logic               pc_write,
    output logic               halted,
    output logic               illegal,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   instr_count
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Phase masks: memory strobes only in MEM, jump/goto only in EXEC,
    // register write only in WB; halt bit never leaves the base word.
    localparam logic [12:0] EXEC_MASK = 13'b1111100011110;
    localparam logic [12:0] MEM_MASK  = 13'b1111101100110;
    localparam logic [12:0] WB_MASK   = 13'b1111110000110;

    state_t             r_state;
    state_t             w_next;
    logic [INSTR_W-1:0] r_ir;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_count;

    logic [OPW-1:0]     w_op;
    logic [31:0]        w_opn;
    logic [12:0]        w_base;
    logic [12:0]        w_ctrl;
    logic               w_branch;
    logic               w_mem;
    logic               w_mtm;
    logic               w_end;
    logic               w_bad;
    logic               w_retire;
    logic               w_unused_ir;

    assign w_op        = r_ir[INSTR_W-1 -: OPW];
    assign w_opn       = 32'(w_op);
    assign w_unused_ir = ^r_ir[INSTR_W-OPW-1:0];

    assign w_branch = (w_opn == 32'd1) || ((w_opn >= 32'd6) && (w_opn <= 32'd8));
    assign w_mem    = (w_opn == 32'd4) || (w_opn == 32'd5);
    assign w_mtm    = (w_opn == 32'd4);
    assign w_end    = (w_opn == 32'd11);
    assign w_bad    = (w_opn >= 32'd13);

    always_comb begin
        w_base = '0;
        case (w_opn)
            32'd0:                      w_base = 13'b0011010000011;
            32'd1, 32'd6, 32'd7, 32'd8: w_base = 13'b0100100010001;
            32'd2:                      w_base = 13'b0101010000011;
            32'd3:                      w_base = 13'b0000010000001;
            32'd4:                      w_base = 13'b0100101000101;
            32'd5:                      w_base = 13'b0100010100101;
            32'd9:                      w_base = 13'b0011010000101;
            32'd10:                     w_base = 13'b0101100001101;
            32'd11:                     w_base = 13'b0100000000000;
            32'd12:                     w_base = 13'b1101100001101;
            default:                    w_base = '0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_ctrl   = '0;
        w_retire = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (fetch_ack) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_next = (w_end || w_bad) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                w_ctrl = w_base & EXEC_MASK;
                if (w_branch) begin
                    w_next   = ST_FETCH;
                    w_retire = 1'b1;
                end else if (w_mem) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM: begin
                w_ctrl = w_base & MEM_MASK;
                if (mem_ack) begin
                    w_next   = w_mtm ? ST_FETCH : ST_WB;
                    w_retire = w_mtm;
                end
            end
            ST_WB: begin
                w_ctrl   = w_base & WB_MASK;
                w_retire = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_HALT: begin
                w_ctrl = 13'b0000000000001;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    // Reset suppresses a retirement that coincides with it in the same cycle.
    assign pc_write    = w_retire & ~reset;
    assign fetch_req   = (r_state == ST_FETCH);
    assign halted      = (r_state == ST_HALT);
    assign state       = r_state;
    assign ctrl        = w_ctrl;
    assign illegal     = r_illegal;
    assign instr_count = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_ir      <= '0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_FETCH) && fetch_ack) r_ir <= instr;
            if ((r_state == ST_DECODE) && w_bad) r_illegal <= 1'b1;
            if (pc_write && (r_count != {CNT_W{1'b1}})) r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: a phase-list model predicts every cycle's outputs,
// with literal spot checks on key control words and counter values.
module tb_control_fsm;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    instr;
    logic          fetch_ack;
    logic          mem_ack;
    logic          fetch_req;
    logic [12:0]   ctrl;
    logic          pc_write;
    logic          halted;
    logic          illegal;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    always #5 clock = ~clock;

    control_fsm #(.INSTR_W(8), .OPW(4), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .instr      (instr),
        .fetch_ack  (fetch_ack),
        .mem_ack    (mem_ack),
        .fetch_req  (fetch_req),
        .ctrl       (ctrl),
        .pc_write   (pc_write),
        .halted     (halted),
        .illegal    (illegal),
        .state      (state),
        .instr_count(instr_count)
    );

    typedef struct {
        int         st;
        logic [12:0] ctrl;
        logic       pcw;
        int         cnt;
        logic       ill;
        logic       fr;
        logic       hl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_count;
    logic m_ill;

    logic [7:0] prog [10] = '{8'h30, 8'h20, 8'h10, 8'h70, 8'h80, 8'h90, 8'h05, 8'h23, 8'h61, 8'h99};

    function automatic logic [12:0] base_of(input int op);
        case (op)
            0:       return 13'b0011010000011;
            1, 6, 7, 8: return 13'b0100100010001;
            2:       return 13'b0101010000011;
            3:       return 13'b0000010000001;
            4:       return 13'b0100101000101;
            5:       return 13'b0100010100101;
            9:       return 13'b0011010000101;
            10:      return 13'b0101100001101;
            11:      return 13'b0100000000000;
            12:      return 13'b1101100001101;
            default: return 13'b0;
        endcase
    endfunction

    // ph: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT
    function automatic logic [12:0] ctrl_for(input int op, input int ph);
        logic [12:0] b;
        logic [12:0] r;
        bit          keep;
        if (ph <= 1) return 13'b0;
        if (ph == 5) return 13'b0000000000001;
        b = base_of(op);
        r = '0;
        for (int i = 0; i < 13; i++) begin
            case (i)
                7:       keep = (ph == 4);
                6, 5:    keep = (ph == 3);
                4, 3:    keep = (ph == 2);
                0:       keep = 1'b0;
                default: keep = 1'b1;
            endcase
            r[i] = b[i] & keep;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step(input logic fa, input logic ma, input logic rst,
                        input int ph, input int op, input logic pcw);
        exp_t e;
        @(posedge clock);
        #1;
        fetch_ack = fa;
        mem_ack   = ma;
        reset     = rst;
        e.st   = ph;
        e.ctrl = ctrl_for(op, ph);
        e.pcw  = pcw;
        e.cnt  = m_count;
        e.ill  = m_ill;
        e.fr   = (ph == 0);
        e.hl   = (ph == 5);
        exp_q.push_back(e);
        if (rst) begin
            m_count = 0;
            m_ill   = 1'b0;
        end else begin
            if (pcw && m_count < CMAX) m_count++;
            if (ph == 1 && op >= 13) m_ill = 1'b1;
        end
    endtask

    task automatic run(input logic [7:0] ins, input int fw, input int mw, input logic nz);
        int   op;
        logic br;
        op    = int'(ins[7:4]);
        instr = ins;
        repeat (fw) step(1'b0, nz, 1'b0, 0, op, 1'b0);
        step(1'b1, nz, 1'b0, 0, op, 1'b0);
        step(nz, nz, 1'b0, 1, op, 1'b0);
        if (nz) instr = ~ins;
        if (op == 11 || op >= 13) begin
            step(nz, nz, 1'b0, 5, op, 1'b0);
            return;
        end
        br = (op == 1) || (op >= 6 && op <= 8);
        step(nz, nz, 1'b0, 2, op, br);
        if (br) return;
        if (op == 4 || op == 5) begin
            repeat (mw) step(nz, 1'b0, 1'b0, 3, op, 1'b0);
            step(nz, 1'b1, 1'b0, 3, op, op == 4);
            if (op == 4) return;
        end
        step(nz, nz, 1'b0, 4, op, 1'b1);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state",       32'(state),       32'(e.st));
            chk("ctrl",        32'(ctrl),        32'(e.ctrl));
            chk("pc_write",    32'(pc_write),    32'(e.pcw));
            chk("fetch_req",   32'(fetch_req),   32'(e.fr));
            chk("halted",      32'(halted),      32'(e.hl));
            chk("illegal",     32'(illegal),     32'(e.ill));
            chk("instr_count", 32'(instr_count), 32'(e.cnt));
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        fetch_ack = 1'b1;
        mem_ack   = 1'b1;
        instr     = 8'h0F;
        m_count   = 0;
        m_ill     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset     = 1'b0;
        fetch_ack = 1'b0;
        mem_ack   = 1'b0;
        @(negedge clock);
        chk("rst_state",     32'(state),       32'd0);
        chk("rst_fetch_req", 32'(fetch_req),   32'd1);
        chk("rst_ctrl",      32'(ctrl),        32'd0);
        chk("rst_halted",    32'(halted),      32'd0);
        chk("rst_illegal",   32'(illegal),     32'd0);
        chk("rst_count",     32'(instr_count), 32'd0);
        chk("rst_pc_write",  32'(pc_write),    32'd0);

        run(8'h0F, 2, 0, 1'b0);
        @(negedge clock);
        chk("movfw_wb_ctrl", 32'(ctrl), 32'(13'b0011010000010));
        chk("movfw_wb_pcw",  32'(pc_write), 32'd1);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clock);
        chk("movfw_count", 32'(instr_count), 32'd1);

        run(8'h60, 0, 0, 1'b1);
        @(negedge clock);
        chk("jog_exec_ctrl", 32'(ctrl), 32'(13'b0100100010000));
        chk("jog_exec_pcw",  32'(pc_write), 32'd1);

        run(8'hC0, 0, 0, 1'b0);
        @(negedge clock);
        chk("gtb_wb_ctrl", 32'(ctrl), 32'(13'b1101100000100));

        run(8'hA0, 1, 0, 1'b1);
        @(negedge clock);
        chk("gt_wb_ctrl", 32'(ctrl), 32'(13'b0101100000100));

        run(8'h50, 0, 3, 1'b1);
        @(negedge clock);
        chk("mfm_wb_ctrl", 32'(ctrl), 32'(13'b0100010000100));

        run(8'h4A, 0, 1, 1'b0);
        @(negedge clock);
        chk("mtm_mem_ctrl", 32'(ctrl), 32'(13'b0100101000100));
        chk("mtm_mem_pcw",  32'(pc_write), 32'd1);

        for (int i = 0; i < 10; i++) run(prog[i], i % 2, i % 3, 1'(i));
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clock);
        chk("count_saturated", 32'(instr_count), 32'd15);

        run(8'hB3, 0, 0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 5, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 5, 0, 1'b0);
        @(negedge clock);
        chk("end_halted",  32'(halted),  32'd1);
        chk("end_ctrl",    32'(ctrl),    32'd1);
        chk("end_illegal", 32'(illegal), 32'd0);
        step(1'b1, 1'b1, 1'b1, 5, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clock);
        chk("halt_rst_count", 32'(instr_count), 32'd0);

        instr = 8'h50;
        step(1'b1, 1'b0, 1'b0, 0, 5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1, 5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2, 5, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3, 5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 5, 1'b0);
        @(negedge clock);
        chk("memrst_state", 32'(state),       32'd0);
        chk("memrst_count", 32'(instr_count), 32'd0);

        run(8'hE0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5, 0, 1'b0);
        @(negedge clock);
        chk("illegal_flag", 32'(illegal),  32'd1);
        chk("illegal_ctrl", 32'(ctrl),     32'd1);
        chk("illegal_pcw",  32'(pc_write), 32'd0);
        step(1'b0, 1'b0, 1'b1, 5, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clock);
        chk("illrst_flag",  32'(illegal),     32'd0);
        chk("illrst_state", 32'(state),       32'd0);
        chk("illrst_count", 32'(instr_count), 32'd0);

        run(8'hFF, 1, 0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 5, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 5, 0, 1'b0);
        run(8'h0F, 0, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clock);
        chk("recover_count", 32'(instr_count), 32'd1);

        @(negedge clock);
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
